// File: rtl/switch_2x2_4bit_rr.sv
// 2x2 crossbar switch: one FIFO per input, one registered output stage per port,
// and round-robin arbitration whenever both FIFO heads target the same output.
module switch_2x2_4bit_rr #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_dest,
  output logic             in1_ready,
  input  logic             in2_valid,
  input  logic [WIDTH-1:0] in2_data,
  input  logic             in2_dest,
  output logic             in2_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready,
  output logic             out2_valid,
  output logic [WIDTH-1:0] out2_data,
  input  logic             out2_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = WIDTH + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_ZERO = cnt_t'(0);
  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  // Entry layout is {dest, data}; index 0 is input 1, index 1 is input 2.
  logic [EW-1:0]    mem_q [2][DEPTH];
  logic [EW-1:0]    mem_d [2][DEPTH];
  ptr_t             wr_q [2];
  ptr_t             wr_d [2];
  ptr_t             rd_q [2];
  ptr_t             rd_d [2];
  cnt_t             cnt_q [2];
  cnt_t             cnt_d [2];
  logic [1:0]       ov_q;
  logic [1:0]       ov_d;
  logic [WIDTH-1:0] od_q [2];
  logic [WIDTH-1:0] od_d [2];
  // Priority pointer per output: 0 favours input 1, 1 favours input 2.
  logic [1:0]       prio_q;
  logic [1:0]       prio_d;

  logic [1:0]       in_valid_s;
  logic [1:0]       in_dest_s;
  logic [WIDTH-1:0] in_data_s [2];
  logic [1:0]       out_ready_s;
  logic [1:0]       hvld_s;
  logic [1:0]       hdest_s;
  logic [WIDTH-1:0] hdata_s [2];
  logic [1:0]       load_s;
  logic [1:0]       req_s [2];
  logic [1:0]       gnt_s [2];
  logic [1:0]       push_s;
  logic [1:0]       pop_s;

  assign in_valid_s  = {in2_valid, in1_valid};
  assign in_dest_s   = {in2_dest, in1_dest};
  assign in_data_s[0] = in1_data;
  assign in_data_s[1] = in2_data;
  assign out_ready_s = {out2_ready, out1_ready};

  // Arbitration, output-stage and FIFO next-state logic.
  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    ov_d   = ov_q;
    od_d   = od_q;
    prio_d = prio_q;
    pop_s  = 2'b00;
    push_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      hvld_s[i]  = (cnt_q[i] != CNT_ZERO);
      hdest_s[i] = mem_q[i][rd_q[i]][WIDTH];
      hdata_s[i] = mem_q[i][rd_q[i]][WIDTH-1:0];
    end
    for (int m = 0; m < 2; m++) begin
      load_s[m]   = !ov_q[m] || out_ready_s[m];
      req_s[m][0] = hvld_s[0] && (hdest_s[0] == m[0]);
      req_s[m][1] = hvld_s[1] && (hdest_s[1] == m[0]);
      gnt_s[m][0] = load_s[m] && req_s[m][0] && (!req_s[m][1] || (prio_q[m] == 1'b0));
      gnt_s[m][1] = load_s[m] && req_s[m][1] && (!req_s[m][0] || (prio_q[m] == 1'b1));
      if (load_s[m] && req_s[m][0] && req_s[m][1]) begin
        prio_d[m] = ~prio_q[m];
      end else begin
        prio_d[m] = prio_q[m];
      end
      if (gnt_s[m][0]) begin
        ov_d[m] = 1'b1;
        od_d[m] = hdata_s[0];
      end else if (gnt_s[m][1]) begin
        ov_d[m] = 1'b1;
        od_d[m] = hdata_s[1];
      end else if (out_ready_s[m]) begin
        ov_d[m] = 1'b0;
      end else begin
        ov_d[m] = ov_q[m];
      end
    end
    for (int i = 0; i < 2; i++) begin
      pop_s[i]  = gnt_s[0][i] || gnt_s[1][i];
      push_s[i] = in_valid_s[i] && (cnt_q[i] != CNT_FULL);
      if (push_s[i]) begin
        mem_d[i][wr_q[i]] = {in_dest_s[i], in_data_s[i]};
        wr_d[i] = wr_q[i] + PTR_ONE;
      end else begin
        wr_d[i] = wr_q[i];
      end
      if (pop_s[i]) begin
        rd_d[i] = rd_q[i] + PTR_ONE;
      end else begin
        rd_d[i] = rd_q[i];
      end
      case ({push_s[i], pop_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // State registers; reset overrides any push, pop or load in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
        od_q[i]  <= '0;
      end
      ov_q   <= 2'b00;
      prio_q <= 2'b00;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      ov_q   <= ov_d;
      od_q   <= od_d;
      prio_q <= prio_d;
    end
  end

  assign in1_ready  = (cnt_q[0] != CNT_FULL);
  assign in2_ready  = (cnt_q[1] != CNT_FULL);
  assign out1_valid = ov_q[0];
  assign out1_data  = od_q[0];
  assign out2_valid = ov_q[1];
  assign out2_data  = od_q[1];

endmodule

// File: tb/tb_switch_2x2_4bit_rr.sv
// Directed bench for switch_2x2_4bit_rr: routing, round-robin, backpressure,
// reset flush and FIFO pointer wrap, each checked against hand-computed values.
module tb_switch_2x2_4bit_rr;

  logic       clk;
  logic       rst;
  logic       in1_valid, in1_dest, in1_ready;
  logic [3:0] in1_data;
  logic       in2_valid, in2_dest, in2_ready;
  logic [3:0] in2_data;
  logic       out1_valid, out1_ready;
  logic [3:0] out1_data;
  logic       out2_valid, out2_ready;
  logic [3:0] out2_data;

  int total = 0;
  int bad   = 0;

  switch_2x2_4bit_rr #(.WIDTH(4), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_dest(in1_dest), .in1_ready(in1_ready),
    .in2_valid(in2_valid), .in2_data(in2_data), .in2_dest(in2_dest), .in2_ready(in2_ready),
    .out1_valid(out1_valid), .out1_data(out1_data), .out1_ready(out1_ready),
    .out2_valid(out2_valid), .out2_data(out2_data), .out2_ready(out2_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    in1_valid = 1'b0; in1_data = 4'h0; in1_dest = 1'b0;
    in2_valid = 1'b0; in2_data = 4'h0; in2_dest = 1'b0;
    out1_ready = 1'b1; out2_ready = 1'b1;
    step();
    step();
    chk("rst_out1_valid", {7'd0, out1_valid}, 8'd0);
    chk("rst_out2_valid", {7'd0, out2_valid}, 8'd0);
    chk("rst_out1_data", {4'd0, out1_data}, 8'h00);
    chk("rst_out2_data", {4'd0, out2_data}, 8'h00);
    rst = 1'b0;
    step();
    chk("rst_in1_ready", {7'd0, in1_ready}, 8'd1);
    chk("rst_in2_ready", {7'd0, in2_ready}, 8'd1);

    // Parallel routing to different outputs.
    in1_valid = 1'b1; in1_data = 4'b1010; in1_dest = 1'b0;
    in2_valid = 1'b1; in2_data = 4'b0101; in2_dest = 1'b1;
    step();
    in1_valid = 1'b0; in2_valid = 1'b0;
    step();
    chk("par_out1_valid", {7'd0, out1_valid}, 8'd1);
    chk("par_out1_data", {4'd0, out1_data}, 8'h0a);
    chk("par_out2_valid", {7'd0, out2_valid}, 8'd1);
    chk("par_out2_data", {4'd0, out2_data}, 8'h05);
    step();
    chk("handoff_out1_valid", {7'd0, out1_valid}, 8'd0);
    chk("handoff_out1_hold", {4'd0, out1_data}, 8'h0a);

    // Contention on out1: round-robin starting with input 1.
    in1_valid = 1'b1; in1_data = 4'b1111; in1_dest = 1'b0;
    in2_valid = 1'b1; in2_data = 4'b0000; in2_dest = 1'b0;
    step();
    in1_data = 4'b0001; in2_data = 4'b0010;
    step();
    in1_valid = 1'b0; in2_valid = 1'b0;
    chk("rr_w0_valid", {7'd0, out1_valid}, 8'd1);
    chk("rr_w0_data", {4'd0, out1_data}, 8'h0f);
    step();
    chk("rr_w1_valid", {7'd0, out1_valid}, 8'd1);
    chk("rr_w1_data", {4'd0, out1_data}, 8'h00);
    step();
    chk("rr_w2_valid", {7'd0, out1_valid}, 8'd1);
    chk("rr_w2_data", {4'd0, out1_data}, 8'h01);
    step();
    chk("rr_w3_valid", {7'd0, out1_valid}, 8'd1);
    chk("rr_w3_data", {4'd0, out1_data}, 8'h02);
    chk("rr_out2_idle", {7'd0, out2_valid}, 8'd0);
    step();
    chk("rr_drained", {7'd0, out1_valid}, 8'd0);

    // Backpressure on out2.
    out2_ready = 1'b0;
    in1_valid = 1'b1; in1_data = 4'b0011; in1_dest = 1'b1;
    step();
    in1_data = 4'b0100;
    step();
    chk("bp_first_load", {4'd0, out2_data}, 8'h03);
    chk("bp_ready_mid", {7'd0, in1_ready}, 8'd1);
    in1_data = 4'b0101;
    step();
    in1_valid = 1'b0;
    chk("bp_full_ready", {7'd0, in1_ready}, 8'd0);
    chk("bp_hold_valid", {7'd0, out2_valid}, 8'd1);
    chk("bp_hold_data", {4'd0, out2_data}, 8'h03);
    step();
    chk("bp_hold_data2", {4'd0, out2_data}, 8'h03);
    chk("bp_still_full", {7'd0, in1_ready}, 8'd0);
    out2_ready = 1'b1;
    step();
    chk("bp_drain1", {4'd0, out2_data}, 8'h04);
    chk("bp_ready_back", {7'd0, in1_ready}, 8'd1);
    step();
    chk("bp_drain2_valid", {7'd0, out2_valid}, 8'd1);
    chk("bp_drain2", {4'd0, out2_data}, 8'h05);
    step();
    chk("bp_empty", {7'd0, out2_valid}, 8'd0);

    // Reset flush with full FIFOs and valid outputs.
    out1_ready = 1'b0; out2_ready = 1'b0;
    in1_valid = 1'b1; in1_data = 4'b1000; in1_dest = 1'b0;
    in2_valid = 1'b1; in2_data = 4'b1001; in2_dest = 1'b1;
    step();
    in1_data = 4'b1100; in2_data = 4'b1101;
    step();
    in1_data = 4'b1110; in2_data = 4'b1011;
    step();
    chk("pre_rst_out1_valid", {7'd0, out1_valid}, 8'd1);
    chk("pre_rst_full", {6'd0, in2_ready, in1_ready}, 8'd0);
    rst = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;
    in1_data = 4'b0111; in2_data = 4'b0110;
    step();
    rst = 1'b0; in1_valid = 1'b0; in2_valid = 1'b0;
    chk("flush_valids", {6'd0, out2_valid, out1_valid}, 8'd0);
    chk("flush_data", {out2_data, out1_data}, 8'h00);
    chk("flush_readies", {6'd0, in2_ready, in1_ready}, 8'h03);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("flush_no_stale", {6'd0, out2_valid, out1_valid}, 8'd0);
    end

    // Streaming through one FIFO: pointers wrap several times.
    out1_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in1_valid = (i < 8);
      in1_data  = 4'(i + 1);
      in1_dest  = 1'b0;
      step();
      if (i >= 1) begin
        chk("wrap_valid", {7'd0, out1_valid}, 8'd1);
        chk("wrap_data", {4'd0, out1_data}, 8'(i));
      end
    end
    in1_valid = 1'b0;
    step();
    chk("wrap_end", {7'd0, out1_valid}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
